// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit with a
// start/busy/done handshake; results and flags are held until the next completion.
module muldiv_unit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             imul,
   output logic             idiv,
   output logic [WIDTH-1:0] lo_out,
   output logic [WIDTH-1:0] hi_out,
   output logic [7:0]       flags_out
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               op_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [2*WIDTH:0]   acc, acc_nxt;
   logic [WIDTH:0]     mul_sum, rem_sh, trial;
   logic [WIDTH-1:0]   res_lo, res_hi;
   logic [7:0]         res_flags;
   logic               last_iter, div_zero;

   assign last_iter = (state == S_RUN) && (cnt == CNT_W'(WIDTH - 1));
   assign div_zero  = op && (b == '0);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: assign a default before the case so no path leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = div_zero ? S_DONE : S_RUN;
         S_RUN:   if (last_iter) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != S_IDLE);
      done = (state == S_DONE);
      imul = done && !op_q;
      idiv = done && op_q;
   end

   // One iteration: acc holds {carry, hi, lo} for multiply and {0, rem, quot} for divide.
   always_comb begin
      mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
      rem_sh  = acc[2*WIDTH-1:WIDTH-1];
      trial   = rem_sh - {1'b0, b_q};
      if (op_q) begin
         acc_nxt = {1'b0,
                    trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0],
                    acc[WIDTH-2:0], ~trial[WIDTH]};
      end else if (acc[0]) begin
         acc_nxt = {1'b0, mul_sum, acc[WIDTH-1:1]};
      end else begin
         acc_nxt = {1'b0, acc[2*WIDTH:1]};
      end
   end

   always_comb begin
      res_lo    = acc_nxt[WIDTH-1:0];
      res_hi    = acc_nxt[2*WIDTH-1:WIDTH];
      res_flags = '0;
      if (op_q) begin
         res_flags[0] = (res_lo == '0);
      end else begin
         res_flags[0] = (acc_nxt[2*WIDTH-1:0] == '0);
         res_flags[1] = (res_hi != '0);
      end
   end

   // NOTE: operand/accumulator registers are reset too, so an aborted run leaves no stale state.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         op_q      <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         acc       <= '0;
         lo_out    <= '0;
         hi_out    <= '0;
         flags_out <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_q  <= a;
                  b_q  <= b;
                  op_q <= op;
                  cnt  <= '0;
                  acc  <= {{(WIDTH+1){1'b0}}, op ? a : b};
                  if (div_zero) begin
                     lo_out    <= '1;
                     hi_out    <= a;
                     flags_out <= 8'h04;
                  end
               end
            end
            S_RUN: begin
               acc <= acc_nxt;
               cnt <= cnt + CNT_W'(1);
               if (last_iter) begin
                  lo_out    <= res_lo;
                  hi_out    <= res_hi;
                  flags_out <= res_flags;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results are queued at issue time
// and compared (values, strobes, completion cycle) whenever done pulses.
module tb_muldiv_unit;

   localparam int W = 8;

   typedef struct {
      logic [7:0] lo;
      logic [7:0] hi;
      logic [7:0] fl;
      logic       op;
      int         due;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         op = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, imul, idiv;
   logic [W-1:0] lo_out, hi_out;
   logic [7:0]   flags_out;

   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb[$];

   muldiv_unit #(.WIDTH(W), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .imul(imul), .idiv(idiv),
      .lo_out(lo_out), .hi_out(hi_out), .flags_out(flags_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at #1 after a rising edge; start is sampled at the next edge.
   task automatic issue(input logic o, input logic [7:0] x, input logic [7:0] y, input bit push);
      exp_t        e;
      logic [15:0] p;
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      if (push) begin
         e.op  = o;
         e.due = cyc + 1 + ((o && y == 8'd0) ? 0 : W);
         if (!o) begin
            p    = x * y;
            e.lo = p[7:0];
            e.hi = p[15:8];
            e.fl = {6'b0, p[15:8] != 8'd0, p == 16'd0};
         end else if (y == 8'd0) begin
            e.lo = 8'hFF;
            e.hi = x;
            e.fl = 8'h04;
         end else begin
            e.lo = x / y;
            e.hi = x % y;
            e.fl = {7'b0, (x / y) == 8'd0};
         end
         sb.push_back(e);
      end
      step(1);
      start = 1'b0;
      a     = 8'($urandom);
      b     = 8'($urandom);
      op    = 1'($urandom);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         step(1);
         if (sb.size() == 0 && !busy) ok = 1'b1;
      end
      if (!ok) check("timeout_idle", 0, 1);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            check("lo_out", lo_out, e.lo);
            check("hi_out", hi_out, e.hi);
            check("flags_out", flags_out, e.fl);
            check("imul", imul, !e.op);
            check("idiv", idiv, e.op);
            check("done_cycle", cyc, e.due);
         end
      end else if (imul || idiv) begin
         check("strobe_without_done", 1, 0);
      end
   end

   initial begin
      step(2);
      rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_lo", lo_out, 0);
      check("rst_hi", hi_out, 0);
      check("rst_flags", flags_out, 0);

      // 13*11 with busy profile over cycles 1..10
      issue(1'b0, 8'd13, 8'd11, 1'b1);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         check($sformatf("busy_c%0d", c), busy, (c <= 9));
      end
      step(1);
      check("hold_lo", lo_out, 8'h8F);

      issue(1'b0, 8'd255, 8'd255, 1'b1);
      check("no_clear_on_start", lo_out, 8'h8F);
      wait_idle();
      issue(1'b0, 8'd0, 8'd9, 1'b1);
      wait_idle();
      issue(1'b1, 8'd200, 8'd7, 1'b1);
      wait_idle();
      issue(1'b1, 8'd3, 8'd9, 1'b1);
      wait_idle();

      // divide by zero completes in cycle 1, idle in cycle 2
      issue(1'b1, 8'd5, 8'd0, 1'b1);
      @(negedge clk);
      check("dz_busy_c1", busy, 1);
      @(negedge clk);
      check("dz_busy_c2", busy, 0);
      wait_idle();

      // starts in cycles 3 and 9 ignored, cycle 10 accepted
      issue(1'b1, 8'd200, 8'd7, 1'b1);
      step(2);
      issue(1'b0, 8'd2, 8'd2, 1'b0);
      step(5);
      issue(1'b0, 8'd2, 8'd2, 1'b0);
      issue(1'b0, 8'd2, 8'd2, 1'b1);
      wait_idle();

      // reset mid-operation aborts with no completion
      issue(1'b0, 8'd13, 8'd11, 1'b1);
      wait_idle();
      issue(1'b0, 8'd100, 8'd100, 1'b0);
      step(3);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_lo", lo_out, 0);
      check("abort_hi", hi_out, 0);
      check("abort_flags", flags_out, 0);
      step(20);
      issue(1'b0, 8'd100, 8'd100, 1'b1);
      wait_idle();

      for (int i = 0; i < 8; i++) begin
         issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 255)), 1'b1);
         wait_idle();
      end

      check("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 8-bit unsigned multiply/divide unit on the datapath side of the register array.
- Produces the 16-bit result as two bytes:
  - Low byte (product low / quotient) goes to the R1 low-byte input, strobed by imul/idiv.
  - High byte (product high / remainder) is driven out for a later bus write.
  - Flags byte goes to the PSW input.
- Multi-cycle, with start/busy/done handshake driven by the control unit.

Parameters:
- WIDTH, 8, operand width in bits. The result is 2*WIDTH bits. Only 8 is required to be supported.
- CNT_W, 4, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request an operation; sampled only in IDLE
- op  input  1  0 = multiply, 1 = divide; sampled with start
- a  input  WIDTH  multiplicand / dividend; sampled with start
- b  input  WIDTH  multiplier / divisor; sampled with start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; results valid in that cycle and held afterwards
- imul  output  1  equals done AND latched op==0 (R1 write strobe)
- idiv  output  1  equals done AND latched op==1 (R1 write strobe)
- lo_out  output  WIDTH  product[7:0] or quotient
- hi_out  output  WIDTH  product[15:8] or remainder
- flags_out  output  8  bit0 Z, bit1 C (mul overflow), bit2 DZ (divide by zero), bits7..3 = 0

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE; counter=0.
  - busy=done=imul=idiv=0; lo_out=hi_out=0; flags_out=0.
  - Reset has priority over everything else, including mid-operation. An aborted operation produces no done/imul/idiv, and its outputs stay at 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1: latch a, b, op; clear the accumulator; counter=0.
  - If op=1 and b=0, go to DONE. Otherwise go to RUN.
  - start=0: stay in IDLE.
- RUN: one iteration per cycle, exactly WIDTH cycles (counter 0..WIDTH-1), then DONE.
  - Multiply, shift-add: if multiplier LSB=1, add multiplicand into the upper half of the 2*WIDTH+1-bit accumulator; then shift right 1. The carry is kept, so there is no overflow loss.
  - Divide, restoring:
    - Shift {rem,quot} left 1.
    - trial = rem - b, computed in WIDTH+1 bits.
    - If non-negative: rem = trial, quot LSB = 1. Else quot LSB = 0.
- DONE (exactly one cycle):
  - done=1; imul/idiv per latched op. lo_out/hi_out/flags_out are loaded on the edge entering DONE, so they are valid during DONE.
  - Next state IDLE unconditionally. start asserted during DONE is ignored.
- Latency:
  - start sampled at edge 0: busy=1 from cycle 1, done=1 in cycle WIDTH+1 (cycle 9 for WIDTH=8), busy=0 and state IDLE in cycle 10.
  - Divide by zero: done in cycle 1.
- start while busy=1 is ignored, with no queuing. Operand changes while busy have no effect.
- Outputs hold their values until the next completed operation or reset. They are not cleared when start is accepted.
- Flags:
  - Multiply: Z = (16-bit product == 0); C = (hi != 0); DZ = 0.
  - Divide: Z = (quotient == 0); C = 0; DZ = 0.
  - Divide by zero: lo_out = all ones, hi_out = a, flags = 8'h04 (Z=0, C=0).
- All arithmetic is unsigned. Results are exact for the full operand range, 0..255.

Test Plan:
- mul a=13, b=11, start one cycle → done and imul high only in cycle 9; lo_out=8'h8F, hi_out=8'h00, flags_out=8'h00; busy high cycles 1-9.
- mul a=255, b=255 → lo_out=8'h01, hi_out=8'hFE, flags_out=8'h02; then mul a=0, b=9 → lo_out=0, hi_out=0, flags_out=8'h01.
- div a=200, b=7 → done and idiv in cycle 9; lo_out=8'h1C, hi_out=8'h04, flags_out=8'h00. Also div a=3, b=9 → lo_out=0, hi_out=3, flags_out=8'h01.
- div a=5, b=0 → done and idiv in cycle 1; lo_out=8'hFF, hi_out=8'h05, flags_out=8'h04; busy=0 in cycle 2.
- Start div 200/7, then re-assert start with mul 2*2 in cycles 3 and 9 → both ignored; quotient result as above. Start again in cycle 10 → accepted, product 4 with done at cycle 19.
- After a completed mul 13*11, start mul 100*100, then rst=1 at cycle 4 → cycle 5: busy=0, outputs all 0, no done/imul in any later cycle. A new start after reset completes normally.
